// File: rtl/uart_rx_cfg_if.sv
// Serial-line and received-frame signals of the configurable UART receiver.
// The slave side is the receiver; the master side is whoever drives rx and baud_tick.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            baud_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_data;
    logic            parity_err;
    logic            frame_err;

    modport master (
        output rx, baud_tick,
        input  rx_done_tick, rx_data, parity_err, frame_err
    );

    modport slave (
        input  rx, baud_tick,
        output rx_done_tick, rx_data, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable width, parity and stop length.
// It rejects false starts and flags parity and framing errors on every delivered frame.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_cfg_if.slave bus
);
    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int CW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT + 1);

    localparam logic [CW-1:0] S_HALF  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] S_BIT   = CW'(OVS - 1);
    localparam logic [CW-1:0] S_STOP  = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    localparam logic          HAS_PAR = (PARITY_EN != 0);
    localparam logic          ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic            rx_meta, rxs;
    state_t          state, state_n;
    logic [CW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            pbit, pbit_n;
    logic            done_q, done_n;
    logic [DBIT-1:0] data_q, data_n;
    logic            perr_q, perr_n;
    logic            ferr_q, ferr_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            pbit    <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rxs     <= rx_meta;
            state   <= state_n;
            s       <= s_n;
            n       <= n_n;
            b       <= b_n;
            pbit    <= pbit_n;
            done_q  <= done_n;
            data_q  <= data_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        pbit_n  = pbit;
        done_n  = 1'b0;
        data_n  = data_q;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                // Half a bit in: a line back high means a glitch, not a start bit.
                if (bus.baud_tick) begin
                    if (s == S_HALF) begin
                        if (!rxs) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + CW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.baud_tick) begin
                    if (s == S_BIT) begin
                        s_n = '0;
                        b_n = {rxs, b[DBIT-1:1]};
                        n_n = n + NW'(1);
                        if (n == N_LAST)
                            state_n = HAS_PAR ? PAR : STOP;
                    end else begin
                        s_n = s + CW'(1);
                    end
                end
            end
            PAR: begin
                if (bus.baud_tick) begin
                    if (s == S_BIT) begin
                        pbit_n  = rxs;
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + CW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.baud_tick) begin
                    if (s == S_STOP) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        data_n  = b;
                        ferr_n  = ~rxs;
                        perr_n  = HAS_PAR ? (^b ^ pbit ^ ODD_BIT) : 1'b0;
                    end else begin
                        s_n = s + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_done_tick = done_q;
    assign bus.rx_data      = data_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized scoreboard bench for uart_rx_cfg across three frame formats.
// Stimulus pushes expected frames; a negedge monitor pops them on each done pulse.
module tb_uart_rx_cfg;
    localparam int OVS  = 16;
    localparam int NDUT = 3;
    localparam int DB [NDUT] = '{8, 8, 7};
    localparam int SB [NDUT] = '{16, 16, 32};
    localparam int PE [NDUT] = '{0, 1, 0};
    localparam int PO [NDUT] = '{0, 0, 0};

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic baud_tick = 1'b0;
    logic rx_l [NDUT];
    int unsigned div = 0;

    logic       done_w [NDUT];
    logic [8:0] data_w [NDUT];
    logic       perr_w [NDUT];
    logic       ferr_w [NDUT];

    exp_t       sb [$];
    exp_t       mon_e;
    logic [8:0] last_data [NDUT];
    logic       last_perr [NDUT];
    logic       last_ferr [NDUT];
    logic       prev_done [NDUT];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // One baud_tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        div       <= (div == 3) ? 0 : div + 1;
        baud_tick <= (div == 3);
    end

    uart_rx_cfg_if #(.DBIT(8)) if0 ();
    uart_rx_cfg_if #(.DBIT(8)) if1 ();
    uart_rx_cfg_if #(.DBIT(7)) if2 ();

    assign if0.rx = rx_l[0];
    assign if1.rx = rx_l[1];
    assign if2.rx = rx_l[2];
    assign if0.baud_tick = baud_tick;
    assign if1.baud_tick = baud_tick;
    assign if2.baud_tick = baud_tick;

    uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    uart_rx_cfg #(.DBIT(7), .OVS(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign done_w[0] = if0.rx_done_tick;
    assign done_w[1] = if1.rx_done_tick;
    assign done_w[2] = if2.rx_done_tick;
    assign data_w[0] = 9'(if0.rx_data);
    assign data_w[1] = 9'(if1.rx_data);
    assign data_w[2] = 9'(if2.rx_data);
    assign perr_w[0] = if0.parity_err;
    assign perr_w[1] = if1.parity_err;
    assign perr_w[2] = if2.parity_err;
    assign ferr_w[0] = if0.frame_err;
    assign ferr_w[1] = if1.frame_err;
    assign ferr_w[2] = if2.frame_err;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) prev_done[d] = 1'b0;
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done_w[d] === 1'b1) begin
                check("done_width", d, 32'(prev_done[d]), 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done dut%0d actual=pulse required=none", d);
                end else begin
                    mon_e = sb.pop_front();
                    check("dut_id", d, d, mon_e.id);
                    check("rx_data", d, 32'(data_w[d]), 32'(mon_e.data));
                    check("parity_err", d, 32'(perr_w[d]), 32'(mon_e.perr));
                    check("frame_err", d, 32'(ferr_w[d]), 32'(mon_e.ferr));
                end
            end
            prev_done[d] = done_w[d];
        end
    end

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic drive(input int d, input logic v, input int k);
        rx_l[d] = v;
        wait_ticks(k);
    endtask

    task automatic check_outputs(input int d);
        check("hold_data", d, 32'(data_w[d]), 32'(last_data[d]));
        check("hold_perr", d, 32'(perr_w[d]), 32'(last_perr[d]));
        check("hold_ferr", d, 32'(ferr_w[d]), 32'(last_ferr[d]));
        check("idle_done", d, 32'(done_w[d]), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            rx_l[d]      = 1'b1;
            last_data[d] = '0;
            last_perr[d] = 1'b0;
            last_ferr[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Frame model: parity and error flags follow from counting ones in the sent bits.
    task automatic send(input int d, input logic [8:0] data, input bit flip, input bit stop_low, input bit abort);
        logic [8:0] m;
        logic       pbit;
        int         ones;
        exp_t       e;
        m    = data & ((9'h1 << DB[d]) - 9'h1);
        ones = $countones(m);
        pbit = 1'(((ones + PO[d]) % 2)) ^ flip;
        drive(d, 1'b0, OVS);
        for (int i = 0; i < DB[d]; i++) begin
            if (abort && i == 4) begin
                rx_l[d] = m[i];
                wait_ticks(OVS / 2);
                do_reset();
                return;
            end
            drive(d, m[i], OVS);
        end
        if (PE[d] != 0) drive(d, pbit, OVS);
        e.id   = d;
        e.data = m;
        e.perr = (PE[d] != 0) && (((ones + int'(pbit)) % 2) != PO[d]);
        e.ferr = stop_low;
        sb.push_back(e);
        last_data[d] = e.data;
        last_perr[d] = e.perr;
        last_ferr[d] = e.ferr;
        if (stop_low) begin
            drive(d, 1'b0, SB[d] - OVS / 2 + 2);
            drive(d, 1'b1, OVS);
        end else begin
            drive(d, 1'b1, SB[d]);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", -1, sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) rx_l[d] = 1'b1;
        do_reset();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_outputs(d);

        send(0, 9'hA5, 1'b0, 1'b0, 1'b0);
        wait_drain();
        send(0, 9'h5A, 1'b0, 1'b1, 1'b0);
        send(0, 9'h01, 1'b0, 1'b0, 1'b0);
        wait_drain();
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 2 * OVS);
        @(negedge clk);
        check_outputs(0);
        send(0, 9'hC3, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            send(0, 9'($urandom), 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
        wait_drain();

        send(1, 9'h37, 1'b0, 1'b0, 1'b0);
        send(1, 9'h37, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            send(1, 9'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
        wait_drain();
        @(negedge clk);
        check_outputs(1);

        send(2, 9'h7F, 1'b0, 1'b0, 1'b0);
        send(2, 9'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            send(2, 9'($urandom), 1'b0, ($urandom_range(0, 3) == 0), 1'b0);
        wait_drain();

        send(0, 9'hFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_outputs(d);
        drive(0, 1'b1, OVS);
        send(0, 9'h81, 1'b0, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        check_outputs(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
